// File: rtl/vga_sync_if.sv
// VGA timing bundle: pixel enable, coordinates, blanking and syncs.
// The timing generator drives it as master; pixel consumers and pin logic take the slave view.
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator (640x480@60 Hz by default).
// Divides clk down to a pixel enable, runs 10-bit horizontal/vertical counters on that
// enable, and registers the sync/blanking decode of the next counter values so every
// output changes on the same edge as pixel_x/pixel_y.
// Optional: define VGA_SYNC_FRAME_TICK_EN to get a one-clk frame_tick after each
// wrap to (0,0); otherwise frame_tick is tied low.
module vga_sync #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_MAX   = 10'(V_TOTAL - 1);

  // 11-bit bounds so an exclusive end of 1024 still fits
  localparam logic [10:0] H_VIS  = 11'(H_DISPLAY);
  localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS  = 11'(V_DISPLAY);
  localparam logic [10:0] VS_BEG = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_END = 11'(V_DISPLAY + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             p_tick;
  logic [9:0]       h_count, v_count;
  logic [9:0]       h_next, v_next;
  logic             hsync_q, vsync_q, video_q;
  logic             hsync_next, vsync_next, video_next;
  logic             h_wrap, frame_wrap;

  // With CLK_DIV=1 div never leaves 0, so p_tick is constantly high
  assign p_tick = (div == DIV_MAX);

  // Next counter values and their sync/blanking decode
  always_comb begin
    h_wrap     = (h_count == H_MAX);
    frame_wrap = p_tick && h_wrap && (v_count == V_MAX);
    h_next     = h_wrap ? 10'd0 : h_count + 10'd1;
    v_next     = v_count;
    if (h_wrap) begin
      v_next = (v_count == V_MAX) ? 10'd0 : v_count + 10'd1;
    end
    hsync_next = !(({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END));
    vsync_next = !(({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END));
    video_next = ({1'b0, h_next} < H_VIS) && ({1'b0, v_next} < V_VIS);
  end

  // Pixel-rate divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == DIV_MAX) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Counters and registered decode, all advancing together on the pixel enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= 10'd0;
      v_count <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b1;
    end else if (p_tick) begin
      h_count <= h_next;
      v_count <= v_next;
      hsync_q <= hsync_next;
      vsync_q <= vsync_next;
      video_q <= video_next;
    end
  end

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_q;

  // One-clk pulse in the cycle following the wrap to (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= frame_wrap;
    end
  end

  assign vga.frame_tick = frame_q;
`else
  logic unused_frame;
  assign unused_frame   = frame_wrap;
  assign vga.frame_tick = 1'b0;
`endif

  assign vga.p_tick   = p_tick;
  assign vga.pixel_x  = h_count;
  assign vga.pixel_y  = v_count;
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = video_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: three instances (small raster at CLK_DIV=2, small raster at
// CLK_DIV=1, default 640x480 raster). Expected outputs come from the number of clk
// edges since reset release, converted to pixel/line position with plain arithmetic.
module tb_vga_sync;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  logic clk;
  logic rst_n;
  int   k;
  int   cyc;
  int   checks_total;
  int   checks_passed;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  vga_sync_if vga_a ();
  vga_sync_if vga_b ();
  vga_sync_if vga_c ();

  vga_sync #(
    .CLK_DIV(2), .H_DISPLAY(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_DISPLAY(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_a (.clk(clk), .rst_n(rst_n), .vga(vga_a));

  vga_sync #(
    .CLK_DIV(1), .H_DISPLAY(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_DISPLAY(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_b (.clk(clk), .rst_n(rst_n), .vga(vga_b));

  vga_sync dut_c (.clk(clk), .rst_n(rst_n), .vga(vga_c));

  // clk starts high so the first edge is a falling one
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input int kk, input int cd,
                                 input int hd, input int hf, input int hsw, input int hb,
                                 input int vd, input int vf, input int vsw, input int vb);
    exp_t e;
    int ht, vt, n, x, y;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    n  = kk / cd;
    x  = n % ht;
    y  = (n / ht) % vt;
    e.p_tick = ((kk % cd) == cd - 1);
    e.x      = 10'(x);
    e.y      = 10'(y);
    e.vo     = (x < hd) && (y < vd);
    e.hs     = !((x >= hd + hf) && (x < hd + hf + hsw));
    e.vs     = !((y >= vd + vf) && (y < vd + vf + vsw));
`ifdef VGA_SYNC_FRAME_TICK_EN
    e.ft     = (kk > 0) && ((kk % (ht * vt * cd)) == 0);
`else
    e.ft     = 1'b0;
`endif
    return e;
  endfunction

  task automatic push_all();
    q_a.push_back(model(k, 2, 16, 2, 3, 4, 10, 2, 2, 3));
    q_b.push_back(model(k, 1, 16, 2, 3, 4, 10, 2, 2, 3));
    q_c.push_back(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33));
  endtask

  task automatic check(input string name, input exp_t got, input exp_t want);
    checks_total++;
    if (got === want) begin
      checks_passed++;
    end else begin
      $display("FAIL %s cyc=%0d k=%0d got p=%b x=%0d y=%0d vo=%b hs=%b vs=%b ft=%b want p=%b x=%0d y=%0d vo=%b hs=%b vs=%b ft=%b",
               name, cyc, k, got.p_tick, got.x, got.y, got.vo, got.hs, got.vs, got.ft,
               want.p_tick, want.x, want.y, want.vo, want.hs, want.vs, want.ft);
    end
  endtask

  // One clk: count the edge if out of reset, then move rst_n between edges
  task automatic cycle(input logic rst_val);
    @(posedge clk);
    if (rst_n) k++;
    cyc++;
    #2;
    rst_n = rst_val;
    if (!rst_n) k = 0;
    push_all();
  endtask

  // Monitor: samples on the falling edge and compares against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("div2_small", {vga_a.p_tick, vga_a.pixel_x, vga_a.pixel_y, vga_a.video_on,
                             vga_a.hsync, vga_a.vsync, vga_a.frame_tick}, e);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("div1_small", {vga_b.p_tick, vga_b.pixel_x, vga_b.pixel_y, vga_b.video_on,
                             vga_b.hsync, vga_b.vsync, vga_b.frame_tick}, e);
      end
      if (q_c.size() > 0) begin
        e = q_c.pop_front();
        check("default_640", {vga_c.p_tick, vga_c.pixel_x, vga_c.pixel_y, vga_c.video_on,
                              vga_c.hsync, vga_c.vsync, vga_c.frame_tick}, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus: reset before any rising edge, a long clean run, then random resets
  initial begin
    int low_len;
    int high_len;
    k             = 0;
    cyc           = 0;
    checks_total  = 0;
    checks_passed = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 push_all();
    for (int i = 0; i < 3; i++) cycle(1'b0);
    for (int i = 0; i < 6000; i++) cycle(1'b1);
    for (int ep = 0; ep < 12; ep++) begin
      low_len  = $urandom_range(1, 4);
      high_len = $urandom_range(100, 3000);
      for (int i = 0; i < low_len; i++) cycle(1'b0);
      for (int i = 0; i < high_len; i++) cycle(1'b1);
    end
    @(negedge clk);
    #1;
    checks_total++;
    if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) begin
      checks_passed++;
    end else begin
      $display("FAIL drain got %0d/%0d/%0d pending want 0/0/0", q_a.size(), q_b.size(), q_c.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
